// File: rtl/approx_adder_pipe.sv
// Two-stage valid/ready pipelined approximate adder: OR-approximates the low keff bits and adds the upper part exactly.
// Optional exact-shadow error monitor is enabled by defining APPROX_ADDER_ERR_MON_EN.
`timescale 1ns/1ps

module approx_adder_pipe #(
  parameter int WIDTH      = 4,
  parameter int APPROX_MAX = 2,
  parameter int ET         = 2,
  parameter int CNT_W      = 16,
  localparam int K_W       = (APPROX_MAX > 0) ? $clog2(APPROX_MAX + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [K_W-1:0]   in_k,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_stats,
  output logic [WIDTH:0]   out_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   err_max
);

  logic             s1_valid, s2_valid;
  logic             s1_ready, s2_ready;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [K_W-1:0]   s1_k;
  logic [K_W-1:0]   in_keff;
  logic [WIDTH:0]   s2_sum;
  logic [WIDTH:0]   a_ext, b_ext, lo_mask, approx_sum;

  assign s2_ready = !s2_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  assign in_keff = (in_k > K_W'(APPROX_MAX)) ? K_W'(APPROX_MAX) : in_k;

  // Masking both operands' low bits to zero before the add keeps any carry
  // out of the approximated region, so the upper add sees carry-in 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    a_ext      = {1'b0, s1_a};
    b_ext      = {1'b0, s1_b};
    lo_mask    = ~({(WIDTH + 1){1'b1}} << s1_k);
    approx_sum = ((a_ext & ~lo_mask) + (b_ext & ~lo_mask)) | ((a_ext | b_ext) & lo_mask);
  end

  // NOTE: operand registers carry no reset; their contents are only observed
  // behind s1_valid, which is reset, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (s1_ready && in_valid) begin
      s1_a <= in_a;
      s1_b <= in_b;
      s1_k <= in_keff;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
    end else begin
      if (s1_ready) s1_valid <= in_valid;
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_sum <= approx_sum;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_sum   = s2_sum;

`ifdef APPROX_ADDER_ERR_MON_EN
  logic [WIDTH:0]   exact_sum, s2_err, err_max_q;
  logic [CNT_W-1:0] err_cnt_q;

  assign exact_sum = a_ext + b_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_err <= '0;
    end else if (s2_ready && s1_valid) begin
      s2_err <= exact_sum - approx_sum;
    end
  end

  // A clear takes priority over a coincident transfer, which is then dropped from the stats.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else if (s2_valid && out_ready) begin
      if (32'(s2_err) > ET && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (s2_err > err_max_q) err_max_q <= s2_err;
    end
  end

  assign out_err = s2_err;
  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;

  assign out_err = '0;
  assign err_cnt = '0;
  assign err_max = '0;
`endif

endmodule

// File: doc/approx_adder_pipe.md
Name: approx_adder_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 2+2-bit SOP approximate adder netlists.
- Adds two WIDTH-bit unsigned operands with a runtime-selectable number of approximated LSBs.
- Two-stage valid/ready pipeline; sits between an operand source and a result sink in approximate datapaths.
- Optional exact-shadow error monitor checks results against error threshold ET.

Parameters:
WIDTH, 4, operand width in bits; sum is WIDTH+1 bits
APPROX_MAX, 2, maximum approximated LSBs, 0..WIDTH
ET, 2, error threshold; result violates when exact-approx > ET
CNT_W, 16, width of monitor statistic counters

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_k  input  $clog2(APPROX_MAX+1) (min 1)  approximated LSB count for this transaction
in_valid  input  1  operands valid
in_ready  output  1  block accepts operands this cycle
out_sum  output  WIDTH+1  approximate sum
out_valid  output  1  result valid
out_ready  input  1  sink accepts result
clr_stats  input  1  clears monitor statistics
out_err  output  WIDTH+1  exact minus approximate for current result (monitor)
err_cnt  output  CNT_W  count of delivered results with error > ET (monitor)
err_max  output  WIDTH+1  largest error delivered since clear (monitor)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset, sampled on a clk edge, clears: both stage valids; out_sum, out_err, err_cnt and err_max to 0; in_ready to 1 the cycle after. In-flight data is discarded, even mid-stall.
- Effective k: keff = min(in_k, APPROX_MAX). It is captured with the operands, so a k change affects only later transactions.
- Arithmetic for keff = k:
  - Low k bits: sum[k-1:0] = a[k-1:0] | b[k-1:0].
  - Upper bits: sum[WIDTH:k] = a[WIDTH-1:k] + b[WIDTH-1:k] with carry-in 0. No carry crosses from the low part.
  - k = 0 gives the exact sum. k = WIDTH gives a zero-extended a|b.
  - Consequence: approx <= exact always, so error is non-negative.
- Pipeline:
  - S1 registers a, b and keff.
  - S2 registers the sum (and the monitor error).
  - out_valid reflects S2 valid.
- Handshake:
  - A transfer occurs when valid & ready.
  - s2_ready = !s2_valid | out_ready.
  - s1_ready = !s1_valid | s2_ready.
  - in_ready = s1_ready, combinational from out_ready. No skid buffer.
  - Latency is 2 cycles from accept to out_valid when not stalled. Throughput is 1 result per cycle with out_ready held high.
- Stall: while out_valid & !out_ready, out_sum and out_err hold stable. Both stages fill, then in_ready drops.
- Simultaneous: a full pipeline with out_ready=1 accepts new input in the same cycle, so there are no bubbles.
- Values on in_a/in_b/in_k are ignored when in_valid=0.

Optional Feature:
- Macro APPROX_ADDER_ERR_MON_EN.
- Defined:
  - S2 also computes the exact sum a+b and registers out_err = exact - approx alongside out_sum.
  - Statistics update on each output transfer (out_valid & out_ready):
    - err_cnt += 1 if out_err > ET, saturating at all-ones.
    - err_max = max(err_max, out_err).
  - clr_stats=1 zeroes err_cnt and err_max next edge. If clr_stats coincides with a transfer, the clear wins and that transfer is not counted.
- Undefined: out_err, err_cnt and err_max are tied to 0, clr_stats is ignored, and no exact adder is synthesised.

Test Plan (WIDTH=4, APPROX_MAX=2, ET=2, out_ready=1 unless stated):
- Exact mode: k=0, a=7, b=9 -> out_sum=16 two cycles after accept; out_err=0.
- Approximation:
  - k=2, a=3, b=1 -> out_sum=3, out_err=1, err_cnt stays 0.
  - Next, a=3, b=3 -> out_sum=3, out_err=3, err_cnt=1, err_max=3.
- Clamp and per-transaction k:
  - in_k=3 (clamped to 2), a=15, b=15 -> out_sum=27 (upper 3+3=6 -> 24, low 3).
  - Next beat k=0, same operands -> 30.
- Backpressure: stream 4 beats, out_ready low for 3 cycles -> out_sum held; in_ready=0 once both stages are full; all 4 results arrive in order with no loss or duplication.
- Reset and stats:
  - rst asserted with a full, stalled pipeline -> next cycle out_valid=0, out_sum=0, err_cnt=0, in_ready=1.
  - clr_stats pulse with err_cnt=1 -> err_cnt=0, err_max=0.
